// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fetches message words from memory and
// streams padded 512-bit blocks to the hash core over valid/ready.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [511:0]      blk_data,
  output logic              blk_last,
  output logic [7:0]        blk_idx
);

  localparam int NB = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [15:0] N_G      = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_HI_G = 16'(16 * NB - 2);
  localparam logic [15:0] LEN_LO_G = 16'(16 * NB - 1);
  localparam logic [7:0]  LAST_IDX = 8'(NB - 1);
  localparam logic [63:0] LEN      = 64'(NUM_OF_WORDS) << 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  state_t      state;
  logic [3:0]  slot;
  logic        primed;
  logic [15:0] rd_g;
  logic [15:0] rd_next;
  logic [15:0] slot_g;
  logic [15:0] blk_g;
  logic        need_prime;
  logic        advance;
  logic [31:0] slot_word;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  assign slot_g  = {4'd0, blk_idx, slot};
  assign blk_g   = {4'd0, blk_idx, 4'd0};
  assign rd_next = rd_g + 16'd1;

  // rd_g tracks the word index on mem_addr; it never crosses into
  // the next block on slot 15 so EMIT parks on that block's word 0.
  always_comb begin
    need_prime = !primed && (slot == 4'd0) && (blk_g < N_G);
    advance    = (rd_next < N_G) && (need_prime || slot != 4'd15);
  end

  always_comb begin
    slot_word = 32'd0;
    unique case (1'b1)
      (slot_g < N_G):       slot_word = mem_read_data;
      (slot_g == N_G):      slot_word = 32'h8000_0000;
      (slot_g == LEN_HI_G): slot_word = LEN[63:32];
      (slot_g == LEN_LO_G): slot_word = LEN[31:0];
      default:              slot_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_last  <= 1'b0;
      blk_idx   <= '0;
      slot      <= '0;
      primed    <= 1'b0;
      rd_g      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            mem_addr <= message_addr;
            rd_g     <= '0;
            blk_idx  <= '0;
            slot     <= '0;
            primed   <= 1'b0;
          end
        end
        LOAD: begin
          if (advance) begin
            rd_g     <= rd_next;
            mem_addr <= mem_addr + ADDR_W'(1);
          end
          if (need_prime) begin
            primed <= 1'b1;
          end else begin
            blk_data <= {blk_data[479:0], slot_word};
            slot     <= slot + 4'd1;
            if (slot == 4'd15) begin
              blk_valid <= 1'b1;
              blk_last  <= (blk_idx == LAST_IDX);
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            if (blk_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              mem_addr <= '0;
            end else begin
              blk_idx <= blk_idx + 8'd1;
              slot    <= '0;
              primed  <= 1'b0;
              state   <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: four instances (N=20,13,14,16)
// checked against a word-list padding model of the message.
module tb_sha256_msg_padder;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         start_s [ND];
  logic [15:0]  addr_s  [ND];
  logic         ready_s [ND];
  logic         busy_s  [ND];
  logic         done_s  [ND];
  logic         mclk_s  [ND];
  logic         we_s    [ND];
  logic [15:0]  maddr_s [ND];
  logic         valid_s [ND];
  logic         last_s  [ND];
  logic [511:0] data_s  [ND];
  logic [7:0]   idx_s   [ND];

  logic [31:0] mem [0:65535];

  int total = 0;
  int bad   = 0;

  logic [511:0] obs_d [$];
  logic [7:0]   obs_i [$];
  logic         obs_l [$];
  int           obs_mchg [$];
  int           obs_timeout;
  int           done_early;
  logic         done_at;
  logic         done_after;

  function automatic int nw_of(input int i);
    case (i)
      0:       return 20;
      1:       return 13;
      2:       return 14;
      default: return 16;
    endcase
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    logic [31:0] rdata;
    always @(posedge clk) rdata <= mem[maddr_s[gi]];
    sha256_msg_padder #(
      .NUM_OF_WORDS(nw_of(gi)),
      .ADDR_W(16)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start_s[gi]),
      .message_addr(addr_s[gi]),
      .busy(busy_s[gi]),
      .done(done_s[gi]),
      .mem_clk(mclk_s[gi]),
      .mem_we(we_s[gi]),
      .mem_addr(maddr_s[gi]),
      .mem_read_data(rdata),
      .blk_valid(valid_s[gi]),
      .blk_ready(ready_s[gi]),
      .blk_data(data_s[gi]),
      .blk_last(last_s[gi]),
      .blk_idx(idx_s[gi])
    );
  end

  function automatic int nb_of(input int n);
    return (n + 3 + 15) / 16;
  endfunction

  // Padded message as a flat word list, sliced into block b.
  function automatic logic [511:0] exp_blk(input int n, input logic [15:0] base,
                                           input int b);
    logic [511:0] r;
    logic [31:0]  w;
    logic [63:0]  len;
    int           g;
    int           nb;
    nb  = nb_of(n);
    len = 64'(n) * 64'd32;
    r   = '0;
    for (int k = 0; k < 16; k++) begin
      g = 16 * b + k;
      if (g < n) w = mem[16'(base + 16'(g))];
      else if (g == n) w = 32'h8000_0000;
      else if (g == 16 * nb - 2) w = len[63:32];
      else if (g == 16 * nb - 1) w = len[31:0];
      else w = 32'd0;
      r[511 - 32 * k -: 32] = w;
    end
    return r;
  endfunction

  function automatic logic [511:0] lit20(input int b);
    logic [511:0] r;
    r = '0;
    if (b == 0) begin
      for (int k = 0; k < 16; k++) r[511 - 32 * k -: 32] = 32'(k + 1);
    end else begin
      r = {32'd17, 32'd18, 32'd19, 32'd20, 32'h8000_0000, 320'd0, 32'h0000_0280};
    end
    return r;
  endfunction

  task automatic collect(input int di, input logic [15:0] base, input int stall_max);
    int          n;
    int          chg;
    bit          fin;
    logic [15:0] pm;
    obs_d.delete();
    obs_i.delete();
    obs_l.delete();
    obs_mchg.delete();
    obs_timeout = 0;
    done_early  = 0;
    done_at     = 1'b0;
    done_after  = 1'b0;
    fin         = 0;
    @(negedge clk);
    start_s[di] = 1'b1;
    addr_s[di]  = base;
    @(negedge clk);
    start_s[di] = 1'b0;
    addr_s[di]  = 16'($urandom);
    while (!fin) begin
      n   = 0;
      chg = 0;
      pm  = maddr_s[di];
      while (!valid_s[di] && n < 64) begin
        ready_s[di] = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
        if (maddr_s[di] !== pm) chg++;
        pm = maddr_s[di];
        if (done_s[di]) done_early++;
      end
      ready_s[di] = 1'b0;
      if (!valid_s[di]) begin
        obs_timeout = 1;
        fin = 1;
      end else begin
        obs_d.push_back(data_s[di]);
        obs_i.push_back(idx_s[di]);
        obs_l.push_back(last_s[di]);
        obs_mchg.push_back(chg);
        repeat ($urandom_range(0, stall_max)) @(negedge clk);
        ready_s[di] = 1'b1;
        @(negedge clk);
        ready_s[di] = 1'b0;
        if (obs_l[obs_l.size() - 1]) begin
          done_at = done_s[di];
          @(negedge clk);
          done_after = done_s[di];
          fin = 1;
        end else begin
          if (done_s[di]) done_early++;
          if (obs_d.size() >= 70) begin
            obs_timeout = 1;
            fin = 1;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < ND; i++) begin
      start_s[i] = 1'b0;
      addr_s[i]  = 16'd0;
      ready_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      total++;
      if ({busy_s[i], done_s[i], valid_s[i], last_s[i], we_s[i]} !== 5'b0) begin
        bad++;
        $display("FAIL reset_flags[%0d] got=%b exp=00000", i,
                 {busy_s[i], done_s[i], valid_s[i], last_s[i], we_s[i]});
      end
      total++;
      if (idx_s[i] !== 8'd0 || maddr_s[i] !== 16'd0) begin
        bad++;
        $display("FAIL reset_idx_addr[%0d] got=%h/%h exp=0/0", i, idx_s[i], maddr_s[i]);
      end
      total++;
      if (data_s[i] !== 512'd0) begin
        bad++;
        $display("FAIL reset_data[%0d] got=%h exp=0", i, data_s[i]);
      end
    end
    total++;
    if (mclk_s[0] !== clk) begin
      bad++;
      $display("FAIL mem_clk got=%b exp=%b", mclk_s[0], clk);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_test1_mem();
    for (int i = 0; i < 20; i++) mem[16'h0100 + 16'(i)] = 32'(i + 1);
  endtask

  task automatic check_test1(input string tag);
    total++;
    if (obs_timeout !== 0 || obs_d.size() !== 2) begin
      bad++;
      $display("FAIL %s_count got=%0d timeout=%0d exp=2", tag, obs_d.size(), obs_timeout);
    end
    for (int b = 0; b < 2 && b < obs_d.size(); b++) begin
      total++;
      if (obs_d[b] !== lit20(b)) begin
        bad++;
        $display("FAIL %s_blk%0d got=%h exp=%h", tag, b, obs_d[b], lit20(b));
      end
      total++;
      if (obs_i[b] !== 8'(b) || obs_l[b] !== (b == 1)) begin
        bad++;
        $display("FAIL %s_idx_last%0d got=%0d/%b exp=%0d/%b", tag, b, obs_i[b], obs_l[b],
                 b, b == 1);
      end
    end
    total++;
    if (done_at !== 1'b1 || done_after !== 1'b0 || done_early !== 0) begin
      bad++;
      $display("FAIL %s_done got=%b%b early=%0d exp=10 early=0", tag, done_at, done_after,
               done_early);
    end
  endtask

  task automatic test_msg20();
    load_test1_mem();
    collect(0, 16'h0100, 0);
    check_test1("msg20");
    total++;
    if (busy_s[0] !== 1'b0 || maddr_s[0] !== 16'd0) begin
      bad++;
      $display("FAIL msg20_idle got=%b/%h exp=0/0", busy_s[0], maddr_s[0]);
    end
  endtask

  task automatic test_stall();
    logic [15:0]  base;
    logic [511:0] d0;
    logic [7:0]   i0;
    logic [15:0]  a0;
    int           n;
    int           unstable;
    base = 16'($urandom);
    unstable = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    addr_s[0]  = base;
    @(negedge clk);
    start_s[0] = 1'b0;
    n = 0;
    while (!valid_s[0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (valid_s[0] !== 1'b1 || n !== 17) begin
      bad++;
      $display("FAIL stall_latency got=%0d valid=%b exp=17", n, valid_s[0]);
    end
    d0 = data_s[0];
    i0 = idx_s[0];
    a0 = maddr_s[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (data_s[0] !== d0 || idx_s[0] !== i0 || maddr_s[0] !== a0 || valid_s[0] !== 1'b1)
        unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL stall_hold got=%0d exp=0", unstable);
    end
    total++;
    if (d0 !== exp_blk(20, base, 0)) begin
      bad++;
      $display("FAIL stall_blk0 got=%h exp=%h", d0, exp_blk(20, base, 0));
    end
    ready_s[0] = 1'b1;
    @(negedge clk);
    ready_s[0] = 1'b0;
    n = 0;
    while (!valid_s[0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (data_s[0] !== exp_blk(20, base, 1) || last_s[0] !== 1'b1 || idx_s[0] !== 8'd1) begin
      bad++;
      $display("FAIL stall_blk1 got=%h last=%b idx=%0d exp=%h last=1 idx=1", data_s[0],
               last_s[0], idx_s[0], exp_blk(20, base, 1));
    end
    ready_s[0] = 1'b1;
    @(negedge clk);
    ready_s[0] = 1'b0;
    total++;
    if (done_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL stall_done got=%b exp=1", done_s[0]);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] base;
    base = 16'($urandom);
    collect(1, base, 3);
    total++;
    if (obs_timeout !== 0 || obs_d.size() !== 1) begin
      bad++;
      $display("FAIL n13_count got=%0d exp=1", obs_d.size());
    end else if (obs_d[0][95:0] !== {32'h8000_0000, 32'd0, 32'h0000_01A0} ||
                 obs_d[0] !== exp_blk(13, base, 0) || obs_l[0] !== 1'b1) begin
      bad++;
      $display("FAIL n13_blk got=%h last=%b exp=%h last=1", obs_d[0], obs_l[0],
               exp_blk(13, base, 0));
    end
    base = 16'($urandom);
    collect(2, base, 3);
    total++;
    if (obs_timeout !== 0 || obs_d.size() !== 2) begin
      bad++;
      $display("FAIL n14_count got=%0d exp=2", obs_d.size());
    end else begin
      total++;
      if (obs_d[0][63:0] !== {32'h8000_0000, 32'd0} || obs_d[0] !== exp_blk(14, base, 0)) begin
        bad++;
        $display("FAIL n14_blk0 got=%h exp=%h", obs_d[0], exp_blk(14, base, 0));
      end
      total++;
      if (obs_d[1] !== {480'd0, 32'h0000_01C0} || obs_l[1] !== 1'b1) begin
        bad++;
        $display("FAIL n14_blk1 got=%h last=%b exp=1c0 last=1", obs_d[1], obs_l[1]);
      end
      total++;
      if (obs_mchg[1] !== 0) begin
        bad++;
        $display("FAIL n14_noread got=%0d exp=0", obs_mchg[1]);
      end
    end
    base = 16'($urandom);
    collect(3, base, 3);
    total++;
    if (obs_timeout !== 0 || obs_d.size() !== 2) begin
      bad++;
      $display("FAIL n16_count got=%0d exp=2", obs_d.size());
    end else if (obs_d[1][511:480] !== 32'h8000_0000 || obs_d[1][31:0] !== 32'h0000_0200 ||
                 obs_d[1] !== exp_blk(16, base, 1) || obs_d[0] !== exp_blk(16, base, 0)) begin
      bad++;
      $display("FAIL n16_blks got=%h exp=%h", obs_d[1], exp_blk(16, base, 1));
    end
  endtask

  task automatic test_random();
    logic [15:0] base;
    int          n;
    int          nb;
    int          errs;
    for (int rep = 0; rep < 5; rep++) begin
      for (int di = 0; di < ND; di++) begin
        base = 16'($urandom);
        n    = nw_of(di);
        nb   = nb_of(n);
        collect(di, base, 4);
        total++;
        if (obs_timeout !== 0 || obs_d.size() !== nb) begin
          bad++;
          $display("FAIL rnd_count[%0d] got=%0d exp=%0d", di, obs_d.size(), nb);
        end
        errs = 0;
        for (int b = 0; b < obs_d.size(); b++) begin
          if (obs_d[b] !== exp_blk(n, base, b) || obs_i[b] !== 8'(b) ||
              obs_l[b] !== (b == nb - 1)) begin
            errs++;
            $display("FAIL rnd_blk[%0d].%0d got=%h exp=%h", di, b, obs_d[b],
                     exp_blk(n, base, b));
          end
        end
        total++;
        if (errs !== 0) bad++;
        total++;
        if (done_at !== 1'b1 || done_after !== 1'b0 || done_early !== 0) begin
          bad++;
          $display("FAIL rnd_done[%0d] got=%b%b exp=10", di, done_at, done_after);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    logic [15:0] base;
    int          n;
    int          late_busy;
    base = 16'($urandom);
    late_busy = 0;
    @(negedge clk);
    start_s[1] = 1'b1;
    addr_s[1]  = base;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (4) @(negedge clk);
    start_s[1] = 1'b1;
    addr_s[1]  = base ^ 16'h5555;
    @(negedge clk);
    start_s[1] = 1'b0;
    n = 0;
    while (!valid_s[1] && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (valid_s[1] !== 1'b1 || data_s[1] !== exp_blk(13, base, 0) || last_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL busy_start_blk got=%h exp=%h", data_s[1], exp_blk(13, base, 0));
    end
    ready_s[1] = 1'b1;
    @(negedge clk);
    ready_s[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy_s[1] !== 1'b0) late_busy++;
    end
    total++;
    if (late_busy !== 0) begin
      bad++;
      $display("FAIL busy_start_ignored got=%0d exp=0", late_busy);
    end
  endtask

  task automatic test_reset_mid();
    load_test1_mem();
    @(negedge clk);
    start_s[0] = 1'b1;
    addr_s[0]  = 16'h0100;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_s[0] = 1'b1;
    addr_s[0]  = 16'h2222;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy_s[0], done_s[0], valid_s[0], last_s[0]} !== 4'b0 || idx_s[0] !== 8'd0 ||
        maddr_s[0] !== 16'd0 || data_s[0] !== 512'd0) begin
      bad++;
      $display("FAIL midreset got=%b%b%b%b idx=%0d addr=%h data=%h exp=all zero", busy_s[0],
               done_s[0], valid_s[0], last_s[0], idx_s[0], maddr_s[0], data_s[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    collect(0, 16'h0100, 2);
    check_test1("restart");
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    test_reset();
    test_msg20();
    test_stall();
    test_boundaries();
    test_random();
    test_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
